pattern_recognizer: RTL and testbench
=====================================

Name: pattern_recognizer

Overview:
- Serial bit-stream pattern counter.
- Samples one bit of `x` per rising clock edge and keeps the last four sampled bits.
- Increments a 4-bit wrapping counter each time that window equals the 4-bit pattern selected by `TYPE`.
- Sits downstream of a serial bit source; `y` is the running match count read by monitoring logic.

Parameters:
- PAT0, 4'b1011, pattern detected when TYPE=0 (oldest bit first, MSB = oldest).
- PAT1, 4'b1001, pattern detected when TYPE=1 (oldest bit first, MSB = oldest).
- Both patterns must have MSB=1, so an all-zero history after reset cannot produce a false match.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- x  input  1  serial data bit, sampled on the clk rising edge.
- TYPE  input  1  pattern select: 0 selects PAT0, 1 selects PAT1. Sampled on each edge, not latched.
- y  output  4  number of matches detected since reset, modulo 16. Registered.

Behaviour:
- Reset (reset_n=0, asynchronous): history register hist[2:0] = 3'b000, y = 4'd0. Both hold while reset_n is low.
- After reset_n deasserts, the first rising edge samples x.
- Window at each rising edge: w = {hist[2:0], x}.
  - w[3] is the oldest bit; x is the newest bit.
  - Update: hist <= {hist[1:0], x}.
- Match condition, evaluated on the same edge:
  - w == PAT0 when TYPE=0.
  - w == PAT1 when TYPE=1.
  - On match: y <= y + 1.
- Latency: y reflects a match on the same edge that samples the fourth pattern bit. It is visible as soon as that flop updates; there is no extra pipeline stage.
- Overlap: matches are overlapping; the history is never cleared on a match.
  - PAT0 "1011" in stream 1011011 counts twice.
  - PAT1 "1001" in stream 1001001 counts twice.
- Wrap-around: y is 4 bits. 15 + 1 -> 0, silently, with no saturation or flag.
- TYPE change mid-stream: the history is shared and independent of TYPE. A new TYPE value applies to the window on the very next edge. The history is not flushed and earlier matches are not recounted.
- Fewer than 4 bits since reset: no match is possible, because the zero-filled history and pattern MSB=1 guarantee it. No separate valid counter is required.
- Reset mid-stream: history and y clear immediately. Any partial pattern is discarded.
- `x` and `TYPE` are assumed stable around the rising edge; there is no internal synchronizer.

Test Plan:
- Reset -> y=0. TYPE=0, x = 1,0,1,1,0,1,1 on 7 edges -> y=1 after edge 4, y=2 after edge 7.
- Reset, TYPE=1, x = 1,0,0,1,0,0,1 -> y=1 after edge 4, y=2 after edge 7 (overlapping match).
- Reset, TYPE=0, 28-bit stream 0101101011010101011010110101 (leftmost bit first) -> final y=4.
- Reset, TYPE=0, stream 1011 followed by 16 repetitions of 011 (52 bits, 17 matches) -> y goes 15 then wraps to 0, final y=1.
- Reset, TYPE=0, x = 1,0,1, pulse reset_n low between edges, then x = 1 -> y stays 0 and no match fires.
- Reset, TYPE=0, x = 1,0,0 then switch TYPE=1 and x = 1 -> y=1 (window 1001 matches PAT1).

Source files
------------

// File: rtl/pattern_recognizer.sv
// Serial pattern counter: counts overlapping occurrences of a 4-bit pattern
// in the incoming bit stream, with TYPE choosing which pattern is live.
module pattern_recognizer #(
    parameter logic [3:0] PAT0 = 4'b1011,
    parameter logic [3:0] PAT1 = 4'b1001
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       x,
    input  logic       TYPE,
    output logic [3:0] y
);

    localparam int unsigned HIST_W = 3;
    localparam int unsigned WIN_W  = HIST_W + 1;
    localparam int unsigned CNT_W  = 4;

    logic [HIST_W-1:0] hist;
    logic [WIN_W-1:0]  window_c;
    logic [WIN_W-1:0]  pattern_c;
    logic              match_c;

    // The incoming bit completes the window on the same edge that samples it.
    // Both patterns have MSB=1, so the zero-filled history cannot match early.
    always_comb begin
        window_c  = {hist, x};
        pattern_c = TYPE ? PAT1 : PAT0;
        match_c   = (window_c == pattern_c);
    end

    // History is shared across TYPE values and never flushed on a match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
            y    <= '0;
        end else begin
            hist <= {hist[HIST_W-2:0], x};
            if (match_c) begin
                y <= y + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_recognizer.sv
// Scoreboard bench for pattern_recognizer: a list-based reference model queues the
// expected count for every clock edge and a monitor checks y after each edge.
module tb_pattern_recognizer;

    logic       clk;
    logic       reset_n;
    logic       x;
    logic       type_sel;
    logic [3:0] y;

    int unsigned compared;
    int unsigned mismatched;

    logic [3:0] exp_q[$];
    bit         seen[$];
    int         match_count;

    pattern_recognizer dut (
        .clk    (clk),
        .reset_n(reset_n),
        .x      (x),
        .TYPE   (type_sel),
        .y      (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of every bit seen since reset; a match is the tail
    // of that list spelling the selected pattern.
    task automatic model_clear();
        seen.delete();
        match_count = 0;
    endtask

    task automatic model_edge(input logic b, input logic t);
        logic [3:0] pat;
        logic [3:0] tail;
        pat = t ? 4'b1001 : 4'b1011;
        seen.push_back(b);
        if (seen.size() >= 4) begin
            tail = {seen[seen.size()-4], seen[seen.size()-3],
                    seen[seen.size()-2], seen[seen.size()-1]};
            if (tail == pat) match_count = (match_count + 1) % 16;
        end
        if (seen.size() > 8) void'(seen.pop_front());
    endtask

    // Each call is entered at a negedge and consumes exactly one rising edge.
    task automatic drive(input logic b, input logic t);
        x        = b;
        type_sel = t;
        model_edge(b, t);
        exp_q.push_back(4'(match_count));
        @(negedge clk);
    endtask

    task automatic hold_reset(input int n);
        reset_n = 1'b0;
        x       = 1'b0;
        model_clear();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(4'd0);
            @(negedge clk);
        end
        reset_n = 1'b1;
    endtask

    task automatic check_y(input string name, input logic [3:0] expv);
        compared++;
        if (y !== expv) begin
            mismatched++;
            $display("FAIL %s: y=%0d required=%0d at %0t", name, y, expv, $time);
        end
    endtask

    // Asynchronous reset pulse entirely between two rising edges.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check_y("async_reset_clear", 4'd0);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Monitor: y is registered, so compare just after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            compared++;
            if (y !== e) begin
                mismatched++;
                $display("FAIL scoreboard: y=%0d required=%0d at %0t", y, e, $time);
            end
        end
    end

    initial begin
        logic [27:0] stream28;
        logic [2:0]  rep;
        compared    = 0;
        mismatched  = 0;
        reset_n     = 1'b0;
        x           = 1'b0;
        type_sel    = 1'b0;
        model_clear();
        @(negedge clk);

        // Overlapping PAT0
        hold_reset(2);
        check_y("reset_value", 4'd0);
        drive(1, 0); drive(0, 0); drive(1, 0); drive(1, 0);
        check_y("pat0_first", 4'd1);
        drive(0, 0); drive(1, 0); drive(1, 0);
        check_y("pat0_overlap", 4'd2);

        // Overlapping PAT1
        hold_reset(1);
        drive(1, 1); drive(0, 1); drive(0, 1); drive(1, 1);
        check_y("pat1_first", 4'd1);
        drive(0, 1); drive(0, 1); drive(1, 1);
        check_y("pat1_overlap", 4'd2);

        // 28-bit stream, leftmost bit first
        hold_reset(1);
        stream28 = 28'b0101101011010101011010110101;
        for (int i = 27; i >= 0; i--) drive(stream28[i], 0);
        check_y("stream28", 4'd4);

        // Counter wrap: 1011 then 16 x 011
        hold_reset(1);
        drive(1, 0); drive(0, 0); drive(1, 0); drive(1, 0);
        rep = 3'b011;
        for (int r = 0; r < 16; r++) begin
            for (int j = 2; j >= 0; j--) drive(rep[j], 0);
            if (r == 13) check_y("wrap_at_15", 4'd15);
            if (r == 14) check_y("wrap_to_0", 4'd0);
        end
        check_y("wrap_final", 4'd1);

        // Mid-stream reset discards the partial pattern
        hold_reset(1);
        drive(1, 0); drive(0, 0); drive(1, 0);
        pulse_reset();
        drive(1, 0);
        check_y("reset_discards_partial", 4'd0);

        // TYPE switch mid-stream reuses the history
        hold_reset(1);
        drive(1, 0); drive(0, 0); drive(0, 0);
        drive(1, 1);
        check_y("type_switch", 4'd1);

        // Randomized traffic, biased toward pattern-rich streams
        hold_reset(1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) pulse_reset();
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0 ? ~type_sel : type_sel));
        end

        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
